sram_fifo_ctrl: RTL and testbench



---
 rtl/sram_fifo_pkg.sv | 11 +
 rtl/sram_fifo_outq.sv | 39 +++
 rtl/sram_fifo_ctrl.sv | 70 +++++++
 tb/tb_sram_fifo_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_fifo_pkg.sv
// Shared widths and word/address types for the SRAM-backed FIFO controller.
// Macro is 256x36 1R1W with one-cycle registered read latency.
package sram_fifo_pkg;
  localparam int WIDTH  = 36;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 9;

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/sram_fifo_outq.sv
// Two-entry output queue; entry 0 is always the head and holds its value when drained.
// Push lands at the clock edge; the caller guarantees a free slot at push time.
module sram_fifo_outq
  import sram_fifo_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       cnt
);
  logic [WIDTH-1:0] e0, e1;
  logic             pop_eff;
  logic             slot_hi;

  assign pop_eff    = pop & (cnt != 2'd0);
  // Push goes to entry 1 only if entry 0 will still be occupied after this edge.
  assign slot_hi    = (cnt == 2'd2) || ((cnt == 2'd1) && !pop_eff);
  assign head_valid = (cnt != 2'd0);
  assign head_data  = e0;

  always_ff @(posedge clock) begin
    if (reset) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      if (pop_eff && (cnt == 2'd2)) e0 <= e1;
      if (push) begin
        if (slot_hi) e1 <= push_data;
        else         e0 <= push_data;
      end
      cnt <= cnt + 2'(push) - 2'(pop_eff);
    end
  end
endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller over an external 1R1W SRAM with a 2-entry prefetch queue; 3-cycle empty latency.
// enq_ready depends only on registered SRAM occupancy; deq side is a plain valid/ready head.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [WIDTH-1:0]  enq_bits,
  output logic              deq_valid,
  input  logic              deq_ready,
  output logic [WIDTH-1:0]  deq_bits,
  output logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] sram_W0_addr,
  output logic              sram_W0_en,
  output logic [WIDTH-1:0]  sram_W0_data,
  output logic [ADDR_W-1:0] sram_R0_addr,
  output logic              sram_R0_en,
  input  logic [WIDTH-1:0]  sram_R0_data
);
  addr_t            wr_ptr, rd_ptr;
  logic [CNT_W-1:0] sram_used;
  logic             rd_inflight;
  logic [1:0]       outq_cnt;
  logic             enq_fire, deq_fire, rd_issue;
  logic [2:0]       pending;

  assign enq_ready = (sram_used != CNT_W'(DEPTH));
  assign enq_fire  = enq_valid & enq_ready & !reset;
  assign deq_fire  = deq_valid & deq_ready;

  // sram_used only reflects earlier-cycle writes, so a read never hits the address being written.
  assign pending  = {1'b0, outq_cnt} + {2'b00, rd_inflight};
  assign rd_issue = !reset && (sram_used != '0) && (pending < (3'd2 + {2'b00, deq_fire}));

  assign sram_W0_en   = enq_fire;
  assign sram_W0_addr = wr_ptr;
  assign sram_W0_data = enq_fire ? enq_bits : '0;
  assign sram_R0_en   = rd_issue;
  assign sram_R0_addr = rd_ptr;

  assign count = sram_used + CNT_W'(rd_inflight) + CNT_W'(outq_cnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sram_used   <= '0;
      rd_inflight <= 1'b0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (rd_issue) rd_ptr <= rd_ptr + ADDR_W'(1);
      sram_used   <= sram_used + CNT_W'(enq_fire) - CNT_W'(rd_issue);
      rd_inflight <= rd_issue;
    end
  end

  // Reset clears the queue, so a read returning during reset is dropped.
  sram_fifo_outq u_outq (
    .clock      (clock),
    .reset      (reset),
    .push       (rd_inflight),
    .push_data  (sram_R0_data),
    .pop        (deq_ready),
    .head_valid (deq_valid),
    .head_data  (deq_bits),
    .cnt        (outq_cnt)
  );
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Directed bench for sram_fifo_ctrl with a behavioural 1R1W macro and an in-order scoreboard.
module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

  logic              clock;
  logic              reset;
  logic              enq_valid;
  logic              enq_ready;
  logic [WIDTH-1:0]  enq_bits;
  logic              deq_valid;
  logic              deq_ready;
  logic [WIDTH-1:0]  deq_bits;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] sram_W0_addr;
  logic              sram_W0_en;
  logic [WIDTH-1:0]  sram_W0_data;
  logic [ADDR_W-1:0] sram_R0_addr;
  logic              sram_R0_en;
  logic [WIDTH-1:0]  sram_R0_data;

  sram_fifo_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_ready    (enq_ready),
    .enq_bits     (enq_bits),
    .deq_valid    (deq_valid),
    .deq_ready    (deq_ready),
    .deq_bits     (deq_bits),
    .count        (count),
    .sram_W0_addr (sram_W0_addr),
    .sram_W0_en   (sram_W0_en),
    .sram_W0_data (sram_W0_data),
    .sram_R0_addr (sram_R0_addr),
    .sram_R0_en   (sram_R0_en),
    .sram_R0_data (sram_R0_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Macro model: read data valid only the cycle after R0_en, X otherwise.
  word_t mem [DEPTH];
  always @(posedge clock) begin
    if (sram_W0_en) mem[sram_W0_addr] <= sram_W0_data;
    sram_R0_data <= sram_R0_en ? mem[sram_R0_addr] : {WIDTH{1'bx}};
  end

  int    errors = 0;
  int    checks = 0;
  int    n_acc  = 0;
  int    n_deq  = 0;
  word_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply inputs for the current cycle and score any handshakes that will fire at the next edge.
  task automatic set_in(input logic ev, input word_t eb, input logic dr);
    enq_valid = ev;
    enq_bits  = eb;
    deq_ready = dr;
    #1;
    if (ev && enq_ready) begin
      sb.push_back(eb);
      n_acc++;
    end
    if (dr && deq_valid) begin
      n_deq++;
      chk("deq_expected_word", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) chk("deq_data", 64'(deq_bits), 64'(sb.pop_front()));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    enq_valid = 1'b0;
    enq_bits  = '0;
    deq_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sb.delete();
  endtask

  localparam word_t W1 = 36'h1_2345_6789;
  localparam word_t W2 = 36'hA_BCDE_F012;

  initial begin
    int    acc0, deq0;
    logic  dropped;
    logic  ev, dr;

    do_reset();
    #1;
    chk("rst_enq_ready", 64'(enq_ready), 64'd1);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_bits",  64'(deq_bits),  64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_w0_en",     64'(sram_W0_en), 64'd0);
    chk("rst_w0_data",   64'(sram_W0_data), 64'd0);
    chk("rst_r0_en",     64'(sram_R0_en), 64'd0);
    chk("rst_r0_addr",   64'(sram_R0_addr), 64'd0);

    // Single-word latency: write c0, read issue c1, macro data c2, deq_valid c3.
    set_in(1'b1, W1, 1'b0);
    chk("c0_w0_en",   64'(sram_W0_en), 64'd1);
    chk("c0_w0_addr", 64'(sram_W0_addr), 64'd0);
    chk("c0_w0_data", 64'(sram_W0_data), 64'(W1));
    chk("c0_r0_en",   64'(sram_R0_en), 64'd0);
    tick();
    set_in(1'b0, '0, 1'b0);
    chk("c1_r0_en",   64'(sram_R0_en), 64'd1);
    chk("c1_r0_addr", 64'(sram_R0_addr), 64'd0);
    chk("c1_count",   64'(count), 64'd1);
    chk("c1_deq_valid", 64'(deq_valid), 64'd0);
    tick();
    chk("c2_r0_data", 64'(sram_R0_data), 64'(W1));
    chk("c2_deq_valid", 64'(deq_valid), 64'd0);
    chk("c2_r0_en",   64'(sram_R0_en), 64'd0);
    tick();
    chk("c3_deq_valid", 64'(deq_valid), 64'd1);
    chk("c3_deq_bits",  64'(deq_bits), 64'(W1));
    chk("c3_count",     64'(count), 64'd1);
    set_in(1'b0, '0, 1'b1);
    tick();
    set_in(1'b0, '0, 1'b0);
    chk("drain_deq_valid", 64'(deq_valid), 64'd0);
    chk("drain_count",     64'(count), 64'd0);
    chk("empty_bits_hold", 64'(deq_bits), 64'(W1));

    // Streaming 300 words across the pointer wrap.
    do_reset();
    deq0 = n_deq;
    dropped = 1'b0;
    for (int i = 0; i < 303; i++) begin
      set_in(i < 300, word_t'(i), 1'b1);
      if (!enq_ready) dropped = 1'b1;
      tick();
    end
    chk("stream_deq_count", 64'(n_deq - deq0), 64'd300);
    chk("stream_ready_held", 64'(dropped), 64'd0);
    chk("stream_sb_empty", 64'(sb.size()), 64'd0);

    // Fill to capacity with no dequeue.
    do_reset();
    acc0 = n_acc;
    for (int i = 0; i < 260; i++) begin
      set_in(1'b1, word_t'(36'h8_0000_0000 + i), 1'b0);
      if (i == 258) chk("full_259th_ready", 64'(enq_ready), 64'd0);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    chk("full_accepted", 64'(n_acc - acc0), 64'd258);
    chk("full_count",    64'(count), 64'd258);
    chk("full_enq_ready", 64'(enq_ready), 64'd0);
    deq0 = n_deq;
    for (int i = 0; i < 270; i++) begin
      set_in(1'b0, '0, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    chk("fulldrain_deqs",  64'(n_deq - deq0), 64'd258);
    chk("fulldrain_valid", 64'(deq_valid), 64'd0);
    chk("fulldrain_count", 64'(count), 64'd0);

    // At full, push and pop together: accept resumes only after a read frees SRAM space.
    for (int i = 0; i < 258; i++) begin
      set_in(1'b1, word_t'(36'h4_0000_0000 + i), 1'b0);
      tick();
    end
    set_in(1'b1, word_t'(36'h4_0000_1000), 1'b1);
    chk("fullboth_no_same_cycle", 64'(enq_ready), 64'd0);
    tick();
    set_in(1'b1, word_t'(36'h4_0000_1001), 1'b1);
    chk("fullboth_ready_rises", 64'(enq_ready), 64'd1);
    chk("fullboth_count",       64'(count), 64'd257);
    tick();
    for (int i = 0; i < 280; i++) begin
      set_in(1'b0, '0, 1'b1);
      tick();
    end
    chk("fullboth_sb_empty", 64'(sb.size()), 64'd0);
    chk("fullboth_count_end", 64'(count), 64'd0);

    // Reset while a read is in flight.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, word_t'(36'h2_0000_0000 + i), 1'b0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, 1'b0);
      tick();
    end
    set_in(1'b0, '0, 1'b1);
    chk("rstmid_read_issue", 64'(sram_R0_en), 64'd1);
    tick();
    reset = 1'b1;
    set_in(1'b0, '0, 1'b0);
    tick();
    reset = 1'b0;
    sb.delete();
    #1;
    chk("rstmid_deq_valid", 64'(deq_valid), 64'd0);
    chk("rstmid_count",     64'(count), 64'd0);
    tick();
    chk("rstmid_no_capture", 64'(deq_valid), 64'd0);
    deq0 = n_deq;
    set_in(1'b1, W2, 1'b0);
    tick();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b0, '0, 1'b1);
      tick();
    end
    chk("rstmid_fresh_deqs", 64'(n_deq - deq0), 64'd1);

    // Random valid/ready traffic with a backpressure-heavy phase to reach full.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      ev = ($urandom_range(0, 3) != 0);
      if ((i % 2500) < 800) dr = ($urandom_range(0, 7) == 0);
      else                  dr = ($urandom_range(0, 2) != 0);
      set_in(ev, word_t'({$urandom_range(0, 15), $urandom()}), dr);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      set_in(1'b0, '0, 1'b1);
      tick();
    end
    set_in(1'b0, '0, 1'b0);
    chk("rand_sb_empty",  64'(sb.size()), 64'd0);
    chk("rand_count",     64'(count), 64'd0);
    chk("rand_deq_valid", 64'(deq_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
